// File: rtl/gpio_port_bank_pkg.sv
// gpio_port_bank shared definitions: register indices
// and the bus address width for a given port count.
package gpio_port_bank_pkg;

    localparam logic [2:0] REG_OUT    = 3'd0;
    localparam logic [2:0] REG_DIR    = 3'd1;
    localparam logic [2:0] REG_IN     = 3'd2;
    localparam logic [2:0] REG_IE     = 3'd3;
    localparam logic [2:0] REG_IES    = 3'd4;
    localparam logic [2:0] REG_IFG    = 3'd5;
    localparam logic [2:0] REG_OUTTGL = 3'd6;

    function automatic int gpio_addr_w(input int nports);
        return $clog2(nports) + 3;
    endfunction

endpackage

// File: rtl/gpio_port_bank_port.sv
// gpio_port: one WIDTH-bit port with registers, input
// synchroniser, edge-detect flags and level irq.
module gpio_port
    import gpio_port_bank_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic             wr_en,
    input  logic [2:0]       ridx,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] rval,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic             irq
);

    logic [WIDTH-1:0] out_q, dir_q, ie_q, ies_q, ifg_q;
    logic [WIDTH-1:0] hist_q, ifg_d, sin, evt;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] vld_q;
    logic primed_q;
    logic we;

    assign we  = sel & wr_en;
    assign sin = sync_q[SYNC_STAGES-1];

    // vld_q tracks pipeline fill so the first real sample only primes history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '0;
            vld_q    <= '0;
            hist_q   <= '0;
            primed_q <= 1'b0;
        end else begin
            sync_q[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            hist_q <= sin;
            if (vld_q[SYNC_STAGES-1])
                primed_q <= 1'b1;
        end
    end

    always_comb begin
        evt = '0;
        if (primed_q)
            evt = (sin & ~hist_q & ~ies_q) | (~sin & hist_q & ies_q);
    end

    // a same-cycle edge overrides the write-1-to-clear
    always_comb begin
        ifg_d = ifg_q;
        if (we && ridx == REG_IFG)
            ifg_d = ifg_q & ~wdata;
        ifg_d = ifg_d | evt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            dir_q <= '0;
            ie_q  <= '0;
            ies_q <= '0;
            ifg_q <= '0;
        end else begin
            ifg_q <= ifg_d;
            if (we) begin
                unique case (ridx)
                    REG_OUT:    out_q <= wdata;
                    REG_DIR:    dir_q <= wdata;
                    REG_IE:     ie_q  <= wdata;
                    REG_IES:    ies_q <= wdata;
                    REG_OUTTGL: out_q <= out_q ^ wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rval = '0;
        unique case (ridx)
            REG_OUT: rval = out_q;
            REG_DIR: rval = dir_q;
            REG_IN:  rval = sin;
            REG_IE:  rval = ie_q;
            REG_IES: rval = ies_q;
            REG_IFG: rval = ifg_q;
            default: rval = '0;
        endcase
    end

    assign pin_out = out_q;
    assign pin_oe  = dir_q;
    assign irq     = |(ifg_q & ie_q);

endmodule

// File: rtl/gpio_port_bank.sv
// gpio_port_bank: NPORTS gpio_port instances with
// address decode and a registered read mux.
module gpio_port_bank
    import gpio_port_bank_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int NPORTS      = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [gpio_addr_w(NPORTS)-1:0] addr,
    input  logic                         wr_en,
    input  logic                         rd_en,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         rdata_valid,
    input  logic [NPORTS*WIDTH-1:0]      pin_in,
    output logic [NPORTS*WIDTH-1:0]      pin_out,
    output logic [NPORTS*WIDTH-1:0]      pin_oe,
    output logic [NPORTS-1:0]            irq
);

    localparam int AW = gpio_addr_w(NPORTS);
    localparam int PW = (AW > 3) ? AW - 3 : 1;

    logic [PW-1:0]    pidx;
    logic             pvalid;
    logic [WIDTH-1:0] rsel;
    logic [WIDTH-1:0] prd [NPORTS];

    generate
        if (AW > 3) begin : g_pidx
            assign pidx = addr[AW-1:3];
        end else begin : g_pidx1
            assign pidx = '0;
        end
    endgenerate

    assign pvalid = int'(pidx) < NPORTS;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        gpio_port #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_port (
            .clk     (clk),
            .rst_n   (rst_n),
            .sel     (pvalid && pidx == PW'(p)),
            .wr_en   (wr_en),
            .ridx    (addr[2:0]),
            .wdata   (wdata),
            .pin_in  (pin_in[p*WIDTH +: WIDTH]),
            .rval    (prd[p]),
            .pin_out (pin_out[p*WIDTH +: WIDTH]),
            .pin_oe  (pin_oe[p*WIDTH +: WIDTH]),
            .irq     (irq[p])
        );
    end

    always_comb begin
        rsel = '0;
        for (int p = 0; p < NPORTS; p++)
            if (pvalid && pidx == PW'(p))
                rsel = prd[p];
    end

    // sampled before any same-edge write lands, so reads see the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= rd_en;
            if (rd_en)
                rdata <= rsel;
        end
    end

endmodule
